// File: rtl/dmem_pkg.sv
// Shared types, transfer-size constants and byte-lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    function automatic logic size_legal(input logic [3:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_D);
    endfunction

    function automatic logic [3:0] size_norm(input logic [3:0] sz);
        return size_legal(sz) ? sz : SZ_D;
    endfunction

    function automatic logic [7:0] size_lanes(input logic [3:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the CPU data port (master) and the memory responder (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Byte-addressed storage: 8-lane byte-enable write and combinational 8-byte read starting at i_idx.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic                           i_clk,
    input  logic [7:0]                     i_we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] i_idx,
    input  logic [63:0]                    i_wdata,
    output logic [63:0]                    o_rdata
);

    localparam int AW = $clog2(DEPTH_BYTES);

    // No reset: contents survive a reset of the responder.
    logic [7:0] r_mem [DEPTH_BYTES];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 8; i++) begin
            if (i_we[i]) r_mem[i_idx + AW'(i)] <= i_wdata[8*i +: 8];
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_rd
        assign o_rdata[8*g +: 8] = r_mem[i_idx + AW'(g)];
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed access latency.
// Optional DMEM_ERR_CHECK_EN: reject misaligned, out-of-range or illegal-size requests via resp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    dmem_if.slave  io_dmem
);

    localparam int            AW       = $clog2(DEPTH_BYTES);
    localparam int            CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    dmem_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [3:0]    r_size;
    logic [63:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic          w_access;
    logic          w_acc_write;
    logic [63:0]   w_acc_addr;
    logic [63:0]   w_acc_wdata;
    logic [3:0]    w_acc_size;
    logic          w_err;
    logic [3:0]    w_eff_size;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_lanes;
    logic [7:0]    w_we;
    logic [63:0]   w_lane_mask;
    logic [63:0]   w_arr_rdata;

    assign w_accept = (r_state == IDLE) && io_dmem.req_valid;

    // With LATENCY==1 the access shares the accept edge, so it must use the live request.
    if (LATENCY == 1) begin : g_lat1
        assign w_access    = w_accept;
        assign w_acc_write = io_dmem.req_write;
        assign w_acc_addr  = io_dmem.req_addr;
        assign w_acc_wdata = io_dmem.req_wdata;
        assign w_acc_size  = io_dmem.req_size;
    end else begin : g_latn
        assign w_access    = (r_state == WAIT) && (r_cnt == '0);
        assign w_acc_write = r_write;
        assign w_acc_addr  = r_addr;
        assign w_acc_wdata = r_wdata;
        assign w_acc_size  = r_size;
    end

`ifdef DMEM_ERR_CHECK_EN
    assign w_eff_size = w_acc_size;
    assign w_err = !size_legal(w_acc_size)
                || ((w_acc_addr & (64'(w_acc_size) - 64'd1)) != 64'd0)
                || (w_acc_addr > (64'(DEPTH_BYTES) - 64'(w_acc_size)));
    assign w_idx = w_acc_addr[AW-1:0];
`else
    logic w_unused_addr;
    assign w_eff_size    = size_norm(w_acc_size);
    assign w_err         = 1'b0;
    assign w_idx         = w_acc_addr[AW-1:0] & ~(AW'(w_eff_size) - AW'(1));
    assign w_unused_addr = ^w_acc_addr[63:AW];
`endif

    assign w_lanes = size_lanes(w_eff_size);
    assign w_we    = (w_access && w_acc_write && !w_err) ? w_lanes : 8'h00;

    for (genvar g = 0; g < 8; g++) begin : g_mask
        assign w_lane_mask[8*g +: 8] = {8{w_lanes[g]}};
    end

    dmem_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (io_dmem.req_valid) w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (r_cnt == '0)       w_state_nxt = RESP;
            RESP:    if (io_dmem.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io_dmem.req_ready  = (r_state == IDLE);
        io_dmem.resp_valid = (r_state == RESP);
        io_dmem.resp_rdata = r_rdata;
        io_dmem.resp_err   = r_err;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= io_dmem.req_write;
                r_addr  <= io_dmem.req_addr;
                r_wdata <= io_dmem.req_wdata;
                r_size  <= io_dmem.req_size;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Response registers only change on the edge entering RESP, so they hold under back-pressure.
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_acc_write || w_err) ? 64'd0 : (w_arr_rdata & w_lane_mask);
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [7:0] mref [DEPTH];

    always #5 clk = ~clk;

    dmem_if bus();

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_dmem (bus)
    );

    function automatic logic is_legal(input logic [3:0] s);
        return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
    endfunction

    // Reference behaviour computed directly from the access rules.
    function automatic void model(input logic w, input logic [63:0] a, input logic [63:0] d,
                                  input logic [3:0] s, output logic [63:0] rd, output logic er);
        longint unsigned base;
        int sz;
        rd = '0;
        er = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        if (!is_legal(s) || ((a % 64'(s)) != 0) || (a > 64'(DEPTH) - 64'(s))) begin
            er = 1'b1;
            return;
        end
        sz   = int'(s);
        base = a;
`else
        sz   = is_legal(s) ? int'(s) : 8;
        base = ((a % 64'(DEPTH)) / 64'(sz)) * 64'(sz);
`endif
        for (int i = 0; i < sz; i++) begin
            if (w) mref[base + 64'(i)] = d[8*i +: 8];
            else   rd[8*i +: 8] = mref[base + 64'(i)];
        end
    endfunction

    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [3:0] s,
                       output logic [63:0] rd, output logic er, output int lat);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_size  = s;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready got %0b want 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.resp_rdata;
        er = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic run(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [3:0] s,
                       output logic [63:0] rd, output logic er, output int lat,
                       output logic [63:0] exp_rd, output logic exp_er);
        model(w, a, d, s, exp_rd, exp_er);
        txn(w, a, d, s, rd, er, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready); end
        n_chk++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid); end
        n_chk++; if (bus.resp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
        n_chk++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus.resp_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic init_mem();
        logic [63:0] rd, erd, d;
        logic er, eer;
        int lat;
        for (int a = 0; a < DEPTH; a += 8) begin
            d = {$urandom, $urandom};
            run(1'b1, 64'(a), d, 4'd8, rd, er, lat, erd, eer);
        end
    endtask

    task automatic test_basic();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        run(1'b1, 64'h10, 64'h1122334455667788, 4'd8, rd, er, lat, erd, eer);
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL basic_store_latency: got %0d want %0d", lat, LAT); end
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL basic_store_err: got %0b want 0", er); end
        n_chk++; if (rd !== 64'd0) begin n_fail++; $display("FAIL basic_store_rdata: got %h want 0", rd); end
        run(1'b0, 64'h10, 64'd0, 4'd8, rd, er, lat, erd, eer);
        n_chk++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL basic_load_d: got %h want 1122334455667788", rd); end
        run(1'b0, 64'h12, 64'd0, 4'd2, rd, er, lat, erd, eer);
        n_chk++; if (rd !== 64'h5566) begin n_fail++; $display("FAIL basic_load_h: got %h want 5566", rd); end
        run(1'b0, 64'h17, 64'd0, 4'd1, rd, er, lat, erd, eer);
        n_chk++; if (rd !== 64'h11) begin n_fail++; $display("FAIL basic_load_b: got %h want 11", rd); end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_rd;
        logic er;
        int n;
        model(1'b0, 64'h10, 64'd0, 4'd8, exp_rd, er);
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready: got %0b want 1", bus.req_ready); end
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h10; bus.req_size = 4'd8;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_chk++; if (n != LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", n, LAT); end
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_rd || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%0b rdata=%h ready=%0b want valid=1 rdata=%h ready=0",
                         c, bus.resp_valid, bus.resp_rdata, bus.req_ready, exp_rd);
            end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        n_chk++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%0b valid=%0b want ready=1 valid=0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_err();
        logic [63:0] rd, erd;
        logic er, eer;
        int lat;
        run(1'b1, 64'h13, 64'h00000000AABBCCDD, 4'd4, rd, er, lat, erd, eer);
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL err_latency: got %0d want %0d", lat, LAT); end
`ifdef DMEM_ERR_CHECK_EN
        n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misalign_flag: got %0b want 1", er); end
        n_chk++; if (rd !== 64'd0) begin n_fail++; $display("FAIL err_misalign_rdata: got %h want 0", rd); end
        run(1'b0, 64'h10, 64'd0, 4'd8, rd, er, lat, erd, eer);
        n_chk++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL err_mem_unchanged: got %h want 1122334455667788", rd); end
        run(1'b1, 64'(DEPTH - 4), 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, rd, er, lat, erd, eer);
        n_chk++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_range_flag: got %0b want 1", er); end
`else
        n_chk++; if (er !== 1'b0) begin n_fail++; $display("FAIL noerr_flag: got %0b want 0", er); end
        run(1'b0, 64'h10, 64'd0, 4'd4, rd, er, lat, erd, eer);
        n_chk++; if (rd !== 64'hAABBCCDD) begin n_fail++; $display("FAIL noerr_aligned_write: got %h want aabbccdd", rd); end
        run(1'b0, 64'h14, 64'd0, 4'd4, rd, er, lat, erd, eer);
        n_chk++; if (rd !== 64'h11223344) begin n_fail++; $display("FAIL noerr_neighbour: got %h want 11223344", rd); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [63:0] pre, rd, erd;
        logic er, eer;
        int lat;
        model(1'b0, 64'h20, 64'd0, 4'd8, pre, er);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 64'h20;
        bus.req_wdata = ~pre; bus.req_size = 4'd8;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_rdata !== 64'd0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ready=%0b valid=%0b rdata=%h err=%0b want 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 64'h20, 64'd0, 4'd8, rd, er, lat, erd, eer);
        n_chk++; if (rd !== pre) begin n_fail++; $display("FAIL midreset_dropped_store: got %h want %h", rd, pre); end
    endtask

    task automatic test_ignore();
        logic [63:0] exp_a, bdata, rd, erd;
        logic er, eer;
        int n;
        int lat;
        model(1'b0, 64'h40, 64'd0, 4'd8, exp_a, er);
        bdata = {$urandom, $urandom};
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h40; bus.req_size = 4'd8;
        @(posedge clk); #1;
        bus.req_write = 1'b1; bus.req_addr = 64'h48; bus.req_wdata = bdata;
        n_chk++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_wait_ready: got %0b want 0", bus.req_ready); end
        n = 0;
        while (!bus.resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_chk++; if (bus.resp_rdata !== exp_a) begin n_fail++; $display("FAIL ignore_first_rdata: got %h want %h", bus.resp_rdata, exp_a); end
        @(posedge clk); #1;
        n_chk++;
        if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_resp_hold: got valid=%0b ready=%0b want 1 0", bus.resp_valid, bus.req_ready);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ignore_back_idle: got %0b want 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        model(1'b1, 64'h48, bdata, 4'd8, erd, eer);
        n = 0;
        while (!bus.resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        n_chk++; if (n != LAT) begin n_fail++; $display("FAIL ignore_second_latency: got %0d want %0d", n, LAT); end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        run(1'b0, 64'h48, 64'd0, 4'd8, rd, er, lat, erd, eer);
        n_chk++; if (rd !== bdata) begin n_fail++; $display("FAIL ignore_second_store: got %h want %h", rd, bdata); end
    endtask

    task automatic test_random();
        logic [3:0]  sizes [4] = '{4'd1, 4'd2, 4'd4, 4'd8};
        logic [63:0] a, d, rd, erd;
        logic [3:0]  s;
        logic        w, er, eer;
        int          sel, lat;
        for (int k = 0; k < 300; k++) begin
            w   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            s   = (sel == 0) ? 4'($urandom_range(0, 15)) : sizes[$urandom_range(0, 3)];
            a   = 64'($urandom_range(0, DEPTH - 1));
            d   = {$urandom, $urandom};
            if (sel < 7 && is_legal(s)) a = a & ~(64'(s) - 64'd1);
            if (sel == 9) a[63:32] = $urandom;
            run(w, a, d, s, rd, er, lat, erd, eer);
            n_chk++; if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h (w=%0b a=%h s=%0d)", k, rd, erd, w, a, s); end
            n_chk++; if (er !== eer) begin n_fail++; $display("FAIL rand_err[%0d]: got %0b want %0b (a=%h s=%0d)", k, er, eer, a, s); end
            n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, lat, LAT); end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_size   = 4'd8;
        bus.resp_ready = 1'b0;
        test_reset();
        init_mem();
        test_basic();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
